// File: rtl/tweak_pkg.sv
// Shared definitions for the instruction-word loader: field widths, encodings,
// loader states and the field-tuple payload.
package tweak_pkg;

   localparam int unsigned ENC_W  = 2;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned REGS_W = 12;
   localparam int unsigned DATA_W = 24;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned CNT_W  = 5;

   localparam logic [ENC_W-1:0] ENC_OP0 = 2'b00;
   localparam logic [ENC_W-1:0] ENC_OP1 = 2'b01;
   localparam logic [ENC_W-1:0] ENC_OP2 = 2'b10;
   localparam logic [ENC_W-1:0] ENC_OP3 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } loader_state_e;

   typedef struct packed {
      logic [ENC_W-1:0]  enc;
      logic [OP_W-1:0]   op;
      logic [REGS_W-1:0] regs;
      logic [DATA_W-1:0] data;
   } fld_t;

endpackage

// File: rtl/tweak_prog_loader_if.sv
// Field-tuple input handshake plus instruction-memory write port of the loader.
interface tweak_prog_loader_if;
   import tweak_pkg::*;

   logic                  fld_valid;
   logic                  fld_ready;
   logic [ENC_W-1:0]      fld_enc;
   logic [OP_W-1:0]       fld_op;
   logic [REGS_W-1:0]     fld_regs;
   logic [DATA_W-1:0]     fld_data;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [WORD_W-1:0]     mem_wdata;
   logic                  mem_ack;

   // loader side
   modport slave (
      input  fld_valid, fld_enc, fld_op, fld_regs, fld_data, mem_ack,
      output fld_ready, mem_we, mem_addr, mem_wdata
   );

   // field producer / memory side
   modport master (
      output fld_valid, fld_enc, fld_op, fld_regs, fld_data, mem_ack,
      input  fld_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/tweak_field_packer.sv
// Combinational packer: inverse of the instruction decoder, flagging any nonzero
// field bits the selected encoding has no room for.
module tweak_field_packer
   import tweak_pkg::*;
(
   input  fld_t              fld,
   output logic [WORD_W-1:0] word_c,
   output logic              lossy_c
);

   logic [DATA_W-1:0] low;

   always_comb begin
      low     = '0;
      lossy_c = 1'b0;
      case (fld.enc)
         ENC_OP0: begin
            low     = fld.data;
            lossy_c = |fld.regs;
         end
         ENC_OP1: begin
            low     = {fld.regs[11:8], fld.data[23:4]};
            lossy_c = (|fld.regs[7:0]) | (|fld.data[3:0]);
         end
         ENC_OP2: begin
            low     = {fld.data[23:8], fld.regs[11:4]};
            lossy_c = (|fld.regs[3:0]) | (|fld.data[7:0]);
         end
         default: begin
            low     = {fld.data[23:12], fld.regs[11:0]};
            lossy_c = |fld.data[11:0];
         end
      endcase
      word_c = {fld.enc, fld.op, low};
   end

endmodule

// File: rtl/tweak_prog_loader.sv
// Program loader: accepts field tuples, packs them into instruction words and
// writes them to consecutive (wrapping) memory addresses with an ack handshake.
module tweak_prog_loader
   import tweak_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [CNT_W-1:0]    word_count,
   tweak_prog_loader_if.slave  bus,
   output logic                busy,
   output logic                done,
   output logic                err_lossy
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_ACCEPT = ST_ACCEPT;
   localparam logic [1:0] S_WRITE  = ST_WRITE;
   localparam logic [1:0] S_DONE   = ST_DONE;

   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   fld_t              fld;
   logic [WORD_W-1:0] packed_word;
   logic              packed_lossy;

   assign fld = {bus.fld_enc, bus.fld_op, bus.fld_regs, bus.fld_data};

   tweak_field_packer u_packer (
      .fld     (fld),
      .word_c  (packed_word),
      .lossy_c (packed_lossy)
   );

   // Next state, datapath updates and next-cycle output values
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = base_addr & ADDR_MASK;
               cnt_d   = (word_count > CNT_MAX) ? CNT_MAX : word_count;
               err_d   = 1'b0;
               state_d = (word_count == '0) ? S_DONE : S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (bus.fld_valid) begin
               wdata_d = packed_word;
               err_d   = err_q | packed_lossy;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (bus.mem_ack) begin
               addr_d  = (addr_q + ADDR_W'(1)) & ADDR_MASK;
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_ACCEPT;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_ACCEPT);
      we_d    = (state_d == S_WRITE);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.fld_ready = ready_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_lossy     = err_q;

endmodule

// File: tb/tb_tweak_prog_loader.sv
// Randomized self-checking bench for tweak_prog_loader against an arithmetic
// model of the packing, lossy, addressing and count-clamping rules.
module tb_tweak_prog_loader;
   import tweak_pkg::*;

   localparam int DEPTH = 16;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       start = 1'b0;
   logic [3:0] base_addr = '0;
   logic [4:0] word_count = '0;
   logic       busy, done, err_lossy;

   tweak_prog_loader_if bus ();

   tweak_prog_loader #(.DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .bus        (bus.slave),
      .busy       (busy),
      .done       (done),
      .err_lossy  (err_lossy)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   int wr_seen = 0;
   logic [31:0] last_wdata;

   logic [1:0]  t_enc  [16];
   logic [5:0]  t_op   [16];
   logic [11:0] t_regs [16];
   logic [23:0] t_data [16];

   always @(negedge CLK) if (done) done_seen++;
   always @(posedge CLK) if (RESET_N && bus.mem_we && bus.mem_ack) wr_seen++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference packing written as shift/add arithmetic on the field values.
   function automatic logic [31:0] model_pack(input logic [1:0] e, input logic [5:0] o,
                                              input logic [11:0] r, input logic [23:0] d);
      int unsigned ri, di, low;
      ri = 32'(r);
      di = 32'(d);
      case (e)
         2'd0:    low = di;
         2'd1:    low = (ri / 256) * (1 << 20) + di / 16;
         2'd2:    low = (di / 256) * 256 + ri / 16;
         default: low = (di / 4096) * 4096 + ri;
      endcase
      return (32'(e) << 30) | (32'(o) << 24) | (low % (1 << 24));
   endfunction

   function automatic bit model_lossy(input logic [1:0] e, input logic [11:0] r, input logic [23:0] d);
      int unsigned ri, di;
      ri = 32'(r);
      di = 32'(d);
      case (e)
         2'd0:    return ri != 0;
         2'd1:    return (ri % 256 != 0) || (di % 16 != 0);
         2'd2:    return (ri % 16 != 0) || (di % 256 != 0);
         default: return di % 4096 != 0;
      endcase
   endfunction

   task automatic junk();
      bus.fld_enc  = 2'($urandom);
      bus.fld_op   = 6'($urandom);
      bus.fld_regs = 12'($urandom);
      bus.fld_data = 24'($urandom);
   endtask

   task automatic set_tuple(input int i, input logic [1:0] e, input logic [5:0] o,
                            input logic [11:0] r, input logic [23:0] d);
      t_enc[i] = e; t_op[i] = o; t_regs[i] = r; t_data[i] = d;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 0)
            set_tuple(i, 2'd0, 6'($urandom), 12'h000, 24'($urandom));
         else
            set_tuple(i, 2'($urandom), 6'($urandom), 12'($urandom), 24'($urandom));
      end
   endtask

   // One load session in lockstep: drive at negedge, check at negedge.
   task automatic session(input logic [3:0] base, input logic [4:0] cnt,
                          input int ack_wait, input bit poke);
      int n, d0, w0;
      logic [3:0] a;
      logic [31:0] w;
      bit exp_err;
      n = (int'(cnt) > DEPTH) ? DEPTH : int'(cnt);
      a = 4'(int'(base) % DEPTH);
      exp_err = 1'b0;
      d0 = done_seen;
      w0 = wr_seen;
      @(negedge CLK);
      start = 1'b1; base_addr = base; word_count = cnt;
      @(negedge CLK);
      start = 1'b0; base_addr = 4'($urandom); word_count = 5'($urandom);
      chk("busy_after_start", 32'(busy), 32'd1);
      if (n == 0) begin
         chk("done_cnt0", 32'(done), 32'd1);
         chk("we_cnt0", 32'(bus.mem_we), 32'd0);
      end
      for (int i = 0; i < n; i++) begin
         chk("ready_accept", 32'(bus.fld_ready), 32'd1);
         chk("we_accept", 32'(bus.mem_we), 32'd0);
         repeat ($urandom_range(0, 2)) begin
            bus.fld_valid = 1'b0; junk(); bus.mem_ack = 1'($urandom);
            @(negedge CLK);
            chk("ready_hold", 32'(bus.fld_ready), 32'd1);
         end
         bus.mem_ack = 1'b0;
         bus.fld_valid = 1'b1;
         bus.fld_enc = t_enc[i]; bus.fld_op = t_op[i];
         bus.fld_regs = t_regs[i]; bus.fld_data = t_data[i];
         @(negedge CLK);
         bus.fld_valid = 1'($urandom); junk();
         w = model_pack(t_enc[i], t_op[i], t_regs[i], t_data[i]);
         exp_err = exp_err | model_lossy(t_enc[i], t_regs[i], t_data[i]);
         chk("we_write", 32'(bus.mem_we), 32'd1);
         chk("addr_write", 32'(bus.mem_addr), 32'(a));
         chk("wdata_write", bus.mem_wdata, w);
         chk("ready_write", 32'(bus.fld_ready), 32'd0);
         chk("err_write", 32'(err_lossy), 32'(exp_err));
         last_wdata = bus.mem_wdata;
         for (int k = 0; k < ack_wait; k++) begin
            if (poke && k == 0) begin
               start = 1'b1; base_addr = 4'($urandom); word_count = 5'($urandom);
            end
            @(negedge CLK);
            start = 1'b0;
            bus.fld_valid = 1'($urandom); junk();
            chk("we_wait", 32'(bus.mem_we), 32'd1);
            chk("addr_wait", 32'(bus.mem_addr), 32'(a));
            chk("wdata_wait", bus.mem_wdata, w);
         end
         bus.mem_ack = 1'b1;
         @(negedge CLK);
         bus.mem_ack = 1'b0;
         bus.fld_valid = 1'b0;
         a = 4'((int'(a) + 1) % DEPTH);
      end
      if (n > 0) begin
         chk("done_end", 32'(done), 32'd1);
         chk("we_end", 32'(bus.mem_we), 32'd0);
      end
      @(negedge CLK);
      chk("done_drop", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("err_final", 32'(err_lossy), 32'(exp_err));
      chk("done_pulses", 32'(done_seen - d0), 32'd1);
      chk("write_count", 32'(wr_seen - w0), 32'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      bus.fld_valid = 1'b0;
      bus.mem_ack = 1'b0;
      junk();
      repeat (2) @(negedge CLK);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err_lossy), 32'd0);
      chk("rst_ready", 32'(bus.fld_ready), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      RESET_N = 1'b1;

      set_tuple(0, 2'd3, 6'h30, 12'h001, 24'h000000);
      session(4'd0, 5'd1, 0, 1'b0);
      chk("op3_wdata", last_wdata, 32'hF000_0001);
      chk("op3_err", 32'(err_lossy), 32'd0);

      set_tuple(0, 2'd1, 6'h00, 12'h000, 24'h000010);
      session(4'd7, 5'd1, 1, 1'b0);
      chk("op1_wdata", last_wdata, 32'h4000_0001);
      chk("op1_err", 32'(err_lossy), 32'd0);

      set_tuple(0, 2'd1, 6'h00, 12'h001, 24'h000000);
      session(4'd7, 5'd1, 0, 1'b0);
      chk("op1_lossy_wdata", last_wdata, 32'h4000_0000);
      chk("op1_lossy_err", 32'(err_lossy), 32'd1);

      fill_rand();
      session(4'd14, 5'd4, 3, 1'b1);

      session(4'd3, 5'd0, 0, 1'b0);

      fill_rand();
      session(4'd2, 5'd20, 0, 1'b0);

      // reset asserted between clock edges while a write is pending
      @(negedge CLK);
      start = 1'b1; base_addr = 4'd5; word_count = 5'd3;
      @(negedge CLK);
      start = 1'b0;
      bus.fld_valid = 1'b1; junk();
      @(negedge CLK);
      bus.fld_valid = 1'b0;
      chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
      #2 RESET_N = 1'b0;
      #1;
      chk("midrst_we", 32'(bus.mem_we), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(bus.fld_ready), 32'd0);
      chk("midrst_addr", 32'(bus.mem_addr), 32'd0);
      chk("midrst_wdata", bus.mem_wdata, 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      fill_rand();
      session(4'd9, 5'd2, 1, 1'b0);

      for (int s = 0; s < 8; s++) begin
         fill_rand();
         session(4'($urandom), 5'($urandom_range(0, 20)), $urandom_range(0, 2), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
